// File: rtl/lsu_misalign_ctrl.sv
// rtl/lsu_misalign_ctrl.sv - load/store controller that splits misaligned accesses into byte accesses
module lsu_misalign_ctrl #(
    parameter bit SPLIT_EN = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             stall,
    output logic [31:0]      load_data,
    output logic             mis_trap,
    output logic [CNT_W-1:0] split_count,
    output logic             mem_write,
    output logic             mem_read,
    output logic [2:0]       mem_funct3,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_write;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_acc;
    logic [1:0]       r_k;
    logic [CNT_W-1:0] r_cnt;

    logic        w_legal;
    logic        w_aligned;
    logic        w_mis;
    logic        w_last;
    logic [31:0] w_shift;

    assign w_legal   = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_aligned = (req_funct3[1:0] == 2'b01) ? ~req_addr[0] :
                       (req_funct3[1:0] == 2'b10) ? (req_addr[1:0] == 2'b00) : 1'b1;
    assign w_mis     = req_valid & w_legal & ~w_aligned;
    assign w_last    = (r_funct3[1:0] == 2'b10) ? (r_k == 2'd3) : (r_k == 2'd1);
    assign w_shift   = r_wdata >> {r_k, 3'b000};

    assign split_count = r_cnt;

    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        mis_trap   = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_funct3 = req_funct3;
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
        load_data  = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && w_legal) begin
                    if (w_aligned) begin
                        mem_write = req_write;
                        mem_read  = ~req_write;
                        load_data = mem_rdata;
                    end else if (SPLIT_EN) begin
                        stall  = 1'b1;
                        w_next = S_SPLIT;
                    end else begin
                        mis_trap = 1'b1;
                    end
                end
            end
            S_SPLIT: begin
                stall    = 1'b1;
                mem_addr = r_addr + {30'b0, r_k};
                if (r_write) begin
                    mem_write  = 1'b1;
                    mem_funct3 = 3'b000;
                    mem_wdata  = {24'b0, w_shift[7:0]};
                end else begin
                    mem_read   = 1'b1;
                    mem_funct3 = 3'b100;
                end
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // The held request is deliberately ignored here so it cannot issue twice.
                w_next = S_IDLE;
                case ({r_write, r_funct3})
                    4'b0001: load_data = {{16{r_acc[15]}}, r_acc[15:0]};
                    4'b0101: load_data = {16'b0, r_acc[15:0]};
                    4'b0010: load_data = r_acc;
                    default: load_data = 32'h0;
                endcase
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_write  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_acc    <= 32'h0;
            r_k      <= 2'd0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_mis && SPLIT_EN) begin
                        r_write  <= req_write;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_acc    <= 32'h0;
                        r_k      <= 2'd0;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_SPLIT: begin
                    if (!r_write) begin
                        r_acc[{r_k, 3'b000} +: 8] <= mem_rdata[7:0];
                    end
                    r_k <= r_k + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
